// File: rtl/mips_multicycle_if.sv
// rtl/mips_multicycle_if.sv - shared memory request/ready port of the multi-cycle MIPS core
interface mips_multicycle_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16
);
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mips_multicycle.sv
// rtl/mips_multicycle.sv - multi-cycle MIPS-subset core on one shared memory port
// Optional performance counters are built when MIPS_MC_PERF_EN is defined.
module mips_multicycle #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clock,
    input  logic                reset,
    mips_multicycle_if.master   mem,
    output logic                retire,
    output logic                halted,
    output logic [DATA_W-1:0]   cycle_count,
    output logic [DATA_W-1:0]   instr_count
);
    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d, tgt_q, tgt_d, addr_q, addr_d;
    logic [31:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic              retire_q, retire_d;
    logic [DATA_W-1:0] regs_q [32];
    logic              wr_en;
    logic [4:0]        wr_sel;

    logic [5:0]        op, funct;
    logic [4:0]        rs, rt, rd;
    logic [DATA_W-1:0] imm_d, alu_y;
    logic              r_valid, op_legal;
    logic              unused_shamt;

    assign op           = ir_q[31:26];
    assign rs           = ir_q[25:21];
    assign rt           = ir_q[20:16];
    assign rd           = ir_q[15:11];
    assign funct        = ir_q[5:0];
    assign unused_shamt = ^ir_q[10:6];
    assign imm_d        = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    assign r_valid      = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                          (funct == F_OR)  || (funct == F_SLT);
    assign op_legal     = (op == OP_R) || (op == OP_ADDI) || (op == OP_LW) ||
                          (op == OP_SW) || (op == OP_BEQ) || (op == OP_J);

    always_comb begin
        alu_y = '0;
        case (funct)
            F_ADD:   alu_y = a_q + b_q;
            F_SUB:   alu_y = a_q - b_q;
            F_AND:   alu_y = a_q & b_q;
            F_OR:    alu_y = a_q | b_q;
            F_SLT:   alu_y = DATA_W'($signed(a_q) < $signed(b_q));
            default: alu_y = '0;
        endcase
    end

    // Bus outputs come straight from registered state so they hold steady during a stall.
    assign mem.mem_req   = !reset && (state_q == S_FETCH || state_q == S_MEM);
    assign mem.mem_we    = !reset && (state_q == S_MEM) && (op == OP_SW);
    assign mem.mem_addr  = reset ? '0 : ((state_q == S_MEM) ? addr_q : pc_q);
    assign mem.mem_wdata = reset ? '0 : b_q;
    assign retire        = retire_q;
    assign halted        = (state_q == S_HALT);

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        tgt_d    = tgt_q;
        addr_d   = addr_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        retire_d = 1'b0;
        wr_en    = 1'b0;
        wr_sel   = (op == OP_R) ? rd : rt;
        case (state_q)
            S_FETCH: if (mem.mem_ready) begin
                ir_d    = mem.mem_rdata[31:0];
                pc_d    = pc_q + 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                a_d     = regs_q[rs];
                b_d     = regs_q[rt];
                tgt_d   = pc_q + imm_d[ADDR_W-1:0];
                state_d = op_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: case (op)
                OP_R:        begin res_d = alu_y;       state_d = S_WB; end
                OP_ADDI:     begin res_d = a_q + imm_d; state_d = S_WB; end
                OP_LW, OP_SW: begin
                    addr_d  = a_q[ADDR_W-1:0] + imm_d[ADDR_W-1:0];
                    state_d = S_MEM;
                end
                OP_BEQ: begin
                    if (a_q == b_q) pc_d = tgt_q;
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
                OP_J: begin
                    pc_d     = ADDR_W'(ir_q[25:0]);
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end
                default: state_d = S_HALT;
            endcase
            S_MEM: if (mem.mem_ready) begin
                if (op == OP_SW) begin
                    retire_d = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    res_d   = mem.mem_rdata;
                    state_d = S_WB;
                end
            end
            S_WB: begin
                wr_en    = (op == OP_R && r_valid) || op == OP_ADDI || op == OP_LW;
                retire_d = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            tgt_q    <= '0;
            addr_q   <= '0;
            ir_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            retire_q <= 1'b0;
            for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            tgt_q    <= tgt_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            retire_q <= retire_d;
            if (wr_en && wr_sel != 5'd0) regs_q[wr_sel] <= res_q;
        end
    end

`ifdef MIPS_MC_PERF_EN
    logic [DATA_W-1:0] cyc_q, ins_q;
    // instr_count steps on the same edge that raises retire, so both agree in that cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            cyc_q <= cyc_q + 1'b1;
            if (retire_d) ins_q <= ins_q + 1'b1;
        end
    end
    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif
endmodule

// File: tb/tb_mips_multicycle.sv
// tb/tb_mips_multicycle.sv - scoreboard bench for mips_multicycle with a wait-stated memory model
module tb_mips_multicycle;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        retire, halted;
    logic [31:0] cycle_count, instr_count;

    mips_multicycle_if #(.DATA_W(32), .ADDR_W(16)) mif ();

    mips_multicycle #(.DATA_W(32), .ADDR_W(16), .RESET_PC(16'h0000)) dut (
        .clock(clock), .reset(reset), .mem(mif), .retire(retire), .halted(halted),
        .cycle_count(cycle_count), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

`ifdef MIPS_MC_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] OP_ADDI = 6'b001000, OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BEQ = 6'b000100;
    localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100, F_OR = 6'b100101, F_SLT = 6'b101010;

    logic [31:0] mem [65536];
    int          wait_n = 0;
    int          wcnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          iv_cnt = 0;
    logic [47:0] exp_wr[$], obs_wr[$];
    logic [15:0] exp_fa[$], obs_fa[$];
    int          exp_iv[$], obs_iv[$];

    assign mif.mem_ready = mif.mem_req && (wcnt >= wait_n);
    assign mif.mem_rdata = mem[mif.mem_addr];

    always @(posedge clock) begin
        if (mif.mem_req && mif.mem_ready) begin
            if (mif.mem_we) begin
                mem[mif.mem_addr] = mif.mem_wdata;
                obs_wr.push_back({mif.mem_addr, mif.mem_wdata});
            end else begin
                obs_fa.push_back(mif.mem_addr);
            end
            wcnt <= 0;
        end else if (mif.mem_req) begin
            wcnt <= wcnt + 1;
        end else begin
            wcnt <= 0;
        end
    end

    always @(negedge clock) begin
        if (reset) begin
            iv_cnt = 0;
        end else begin
            iv_cnt++;
            if (retire) begin
                obs_iv.push_back(iv_cnt);
                iv_cnt = 0;
            end
        end
    end

    function automatic logic [31:0] r_op(int rs, int rt, int rd, logic [5:0] fn);
        return {6'b000000, 5'(rs), 5'(rt), 5'(rd), 5'b00000, fn};
    endfunction

    function automatic logic [31:0] i_op(logic [5:0] op, int rs, int rt, int imm);
        return {op, 5'(rs), 5'(rt), 16'(imm)};
    endfunction

    function automatic logic [31:0] j_op(int tgt);
        return {6'b000010, 26'(tgt)};
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        #1;
        obs_iv.delete(); obs_wr.delete(); obs_fa.delete();
        reset = 1'b0;
    endtask

    task automatic wait_retires(int n, int budget, output bit ok);
        int c = 0;
        while (obs_iv.size() < n && c < budget) begin
            @(negedge clock);
            c++;
        end
        ok = (obs_iv.size() >= n);
    endtask

    task automatic test_reset();
        clear_mem();
        mem[0] = i_op(OP_BEQ, 0, 0, -1);
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_checks++;
            if (mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", mif.mem_req); end
        end
        n_checks++;
        if (retire !== 1'b0 || halted !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got retire=%b halted=%b expected 0/0", retire, halted);
        end
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0 || mif.mem_addr !== 16'h0) begin
            n_fail++; $display("FAIL first_fetch: got req=%b we=%b addr=%h expected 1/0/0000", mif.mem_req, mif.mem_we, mif.mem_addr);
        end
        n_checks++;
        if (cycle_count !== 32'd0 || instr_count !== 32'd0) begin
            n_fail++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", cycle_count, instr_count);
        end
    endtask

    task automatic test_arith();
        int pulses = 0;
        bit ok;
        logic [47:0] e, o;
        int ei, oi;
        clear_mem();
        wait_n = 0;
        exp_iv.delete(); exp_wr.delete();
        mem[0]  = i_op(OP_ADDI, 0, 1, 5);
        mem[1]  = i_op(OP_ADDI, 0, 2, -3);
        mem[2]  = r_op(1, 2, 3, F_ADD);
        mem[3]  = r_op(2, 1, 4, F_SLT);
        mem[4]  = r_op(1, 2, 6, F_SUB);
        mem[5]  = r_op(1, 2, 7, F_AND);
        mem[6]  = r_op(1, 2, 8, F_OR);
        mem[7]  = r_op(1, 2, 9, F_SLT);
        mem[8]  = i_op(OP_SW, 0, 3, 100);
        mem[9]  = i_op(OP_SW, 0, 4, 101);
        mem[10] = i_op(OP_SW, 0, 6, 102);
        mem[11] = i_op(OP_SW, 0, 7, 103);
        mem[12] = i_op(OP_SW, 0, 8, 104);
        mem[13] = i_op(OP_SW, 0, 9, 105);
        mem[14] = i_op(OP_ADDI, 0, 0, 7);
        mem[15] = i_op(OP_SW, 0, 0, 106);
        mem[16] = 32'h0000_0000;
        mem[17] = i_op(OP_BEQ, 0, 0, -1);
        for (int i = 0; i < 17; i++) exp_iv.push_back(4);
        exp_iv.push_back(3); exp_iv.push_back(3);
        exp_wr.push_back({16'd100, 32'd2});
        exp_wr.push_back({16'd101, 32'd1});
        exp_wr.push_back({16'd102, 32'd8});
        exp_wr.push_back({16'd103, 32'd5});
        exp_wr.push_back({16'd104, 32'hFFFF_FFFD});
        exp_wr.push_back({16'd105, 32'd0});
        exp_wr.push_back({16'd106, 32'd0});
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (retire) pulses++;
        end
        n_checks++;
        if (pulses != 4) begin n_fail++; $display("FAIL arith_retire_pulses: got %0d expected 4", pulses); end
        n_checks++;
        if (cycle_count !== (PERF ? 32'd16 : 32'd0) || instr_count !== (PERF ? 32'd4 : 32'd0)) begin
            n_fail++; $display("FAIL perf_counters: got %0d/%0d expected %0d/%0d", cycle_count, instr_count,
                               PERF ? 16 : 0, PERF ? 4 : 0);
        end
        wait_retires(19, 300, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL arith_timeout: got %0d retires expected 19", obs_iv.size()); end
        while (exp_iv.size() > 0) begin
            ei = exp_iv.pop_front();
            oi = (obs_iv.size() > 0) ? obs_iv.pop_front() : -1;
            n_checks++;
            if (oi != ei) begin n_fail++; $display("FAIL arith_latency: got %0d expected %0d", oi, ei); end
        end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = (obs_wr.size() > 0) ? obs_wr.pop_front() : 48'hDEAD_DEAD_DEAD;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL arith_store: got %h expected %h", o, e); end
        end
        n_checks++;
        if (obs_wr.size() != 0) begin n_fail++; $display("FAIL arith_extra_stores: got %0d expected 0", obs_wr.size()); end
    endtask

    task automatic test_mem_wait();
        bit ok;
        logic [47:0] e, o;
        int ei, oi;
        int c = 0;
        clear_mem();
        wait_n = 2;
        exp_iv.delete(); exp_wr.delete();
        mem[0] = i_op(OP_ADDI, 0, 3, 2);
        mem[1] = i_op(OP_SW, 0, 3, 10);
        mem[2] = i_op(OP_LW, 0, 5, 10);
        mem[3] = r_op(5, 5, 6, F_ADD);
        mem[4] = i_op(OP_SW, 0, 6, 11);
        mem[5] = i_op(OP_BEQ, 0, 0, -1);
        exp_iv.push_back(6); exp_iv.push_back(8); exp_iv.push_back(9);
        exp_iv.push_back(6); exp_iv.push_back(8); exp_iv.push_back(5);
        exp_wr.push_back({16'd10, 32'd2});
        exp_wr.push_back({16'd11, 32'd4});
        do_reset();
        wait_retires(6, 200, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL wait_timeout: got %0d retires expected 6", obs_iv.size()); end
        while (exp_iv.size() > 0) begin
            ei = exp_iv.pop_front();
            oi = (obs_iv.size() > 0) ? obs_iv.pop_front() : -1;
            n_checks++;
            if (oi != ei) begin n_fail++; $display("FAIL wait_latency: got %0d expected %0d", oi, ei); end
        end
        while (exp_wr.size() > 0) begin
            e = exp_wr.pop_front();
            o = (obs_wr.size() > 0) ? obs_wr.pop_front() : 48'hDEAD_DEAD_DEAD;
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL wait_store: got %h expected %h", o, e); end
        end
        while (!mif.mem_req && c < 10) begin
            @(negedge clock);
            c++;
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if (mif.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_abandon: got req=%b expected 0", mif.mem_req); end
        @(negedge clock);
        n_checks++;
        if (mif.mem_req !== 1'b0 || obs_wr.size() != 0) begin
            n_fail++; $display("FAIL reset_abandon_hold: got req=%b writes=%0d expected 0/0", mif.mem_req, obs_wr.size());
        end
        wait_n = 0;
    endtask

    task automatic test_control();
        bit ok;
        int ei, oi;
        logic [15:0] ea, oa;
        clear_mem();
        wait_n = 0;
        exp_iv.delete(); exp_fa.delete();
        mem[16'h0000] = i_op(OP_BEQ, 1, 0, -2);
        mem[16'hFFFF] = i_op(OP_ADDI, 0, 1, 1);
        mem[16'h0001] = j_op(32'h20);
        mem[16'h0020] = i_op(OP_BEQ, 0, 0, -1);
        exp_iv.push_back(3); exp_iv.push_back(4); exp_iv.push_back(3);
        exp_iv.push_back(3); exp_iv.push_back(3); exp_iv.push_back(3);
        exp_fa.push_back(16'h0000); exp_fa.push_back(16'hFFFF); exp_fa.push_back(16'h0000);
        exp_fa.push_back(16'h0001); exp_fa.push_back(16'h0020); exp_fa.push_back(16'h0020);
        do_reset();
        wait_retires(6, 100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL ctrl_timeout: got %0d retires expected 6", obs_iv.size()); end
        while (exp_iv.size() > 0) begin
            ei = exp_iv.pop_front();
            oi = (obs_iv.size() > 0) ? obs_iv.pop_front() : -1;
            n_checks++;
            if (oi != ei) begin n_fail++; $display("FAIL ctrl_latency: got %0d expected %0d", oi, ei); end
        end
        while (exp_fa.size() > 0) begin
            ea = exp_fa.pop_front();
            oa = (obs_fa.size() > 0) ? obs_fa.pop_front() : 16'hDEAD;
            n_checks++;
            if (oa !== ea) begin n_fail++; $display("FAIL ctrl_fetch_addr: got %h expected %h", oa, ea); end
        end
    endtask

    task automatic test_illegal();
        int bad = 0;
        clear_mem();
        wait_n = 0;
        mem[0] = 32'hFC00_0000;
        do_reset();
        @(negedge clock);
        n_checks++;
        if (halted !== 1'b0) begin n_fail++; $display("FAIL halt_early: got %b expected 0", halted); end
        @(negedge clock);
        n_checks++;
        if (halted !== 1'b1 || mif.mem_req !== 1'b0) begin
            n_fail++; $display("FAIL halt_entry: got halted=%b req=%b expected 1/0", halted, mif.mem_req);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            if (mif.mem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) bad++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL halt_absorb: got %0d bad cycles expected 0", bad); end
        n_checks++;
        if (cycle_count !== (PERF ? 32'd7 : 32'd0) || instr_count !== 32'd0) begin
            n_fail++; $display("FAIL halt_counters: got %0d/%0d expected %0d/0", cycle_count, instr_count, PERF ? 7 : 0);
        end
        mem[0] = i_op(OP_BEQ, 0, 0, -1);
        do_reset();
        #1;
        n_checks++;
        if (halted !== 1'b0 || mif.mem_req !== 1'b1 || mif.mem_addr !== 16'h0) begin
            n_fail++; $display("FAIL halt_recover: got halted=%b req=%b addr=%h expected 0/1/0000", halted, mif.mem_req, mif.mem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_mem_wait();
        test_control();
        test_illegal();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
